// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a read-only video fetcher
// and a read/write CPU port. Each access takes one cycle and is followed by a
// one-cycle ack with registered read data. Video has priority, and neither
// requester can be granted twice in a row.
module ram_arbiter #(
   parameter int Bits = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            vidReq,
   input  logic [Bits-1:0] vidAddr,
   output logic            vidAck,
   output logic [7:0]      vidData,
   input  logic            cpuReq,
   input  logic            cpuWe,
   input  logic [Bits-1:0] cpuAddr,
   input  logic [7:0]      cpuDataIn,
   output logic            cpuAck,
   output logic [7:0]      cpuData,
   output logic            ramWe,
   output logic [Bits-1:0] ramAddr,
   output logic [7:0]      ramDataOut,
   input  logic [7:0]      ramDataIn
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      VID  = 2'd1,
      CPU  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_vidAck;
   logic            r_cpuAck;
   logic [7:0]      r_vidData;
   logic [7:0]      r_cpuData;
   logic            w_vidElig;
   logic            w_cpuElig;
   logic            w_ramWe;
   logic [Bits-1:0] w_ramAddr;

   // A requester is masked while its own access or ack cycle is in progress,
   // so a held request only re-arms once its ack has been seen.
   assign w_vidElig = vidReq && (r_state != VID) && !r_vidAck;
   assign w_cpuElig = cpuReq && (r_state != CPU) && !r_cpuAck;

   // Next-state selection (video first) and RAM port drive from current state
   always_comb begin
      w_next    = IDLE;
      w_ramWe   = 1'b0;
      w_ramAddr = '0;
      if (w_vidElig) begin
         w_next = VID;
      end else if (w_cpuElig) begin
         w_next = CPU;
      end
      case (r_state)
         VID: begin
            w_ramAddr = vidAddr;
         end
         CPU: begin
            w_ramAddr = cpuAddr;
            w_ramWe   = cpuWe;
         end
         default: begin
            w_ramAddr = '0;
            w_ramWe   = 1'b0;
         end
      endcase
   end

   // State register; reset drops straight to IDLE, aborting any access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Video completion: capture RAM data at the end of the VID cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vidAck  <= 1'b0;
         r_vidData <= 8'h00;
      end else begin
         r_vidAck <= (r_state == VID);
         if (r_state == VID) begin
            r_vidData <= ramDataIn;
         end
      end
   end

   // CPU completion: ack every access, capture data only on reads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpuAck  <= 1'b0;
         r_cpuData <= 8'h00;
      end else begin
         r_cpuAck <= (r_state == CPU);
         if ((r_state == CPU) && !cpuWe) begin
            r_cpuData <= ramDataIn;
         end
      end
   end

   assign vidAck     = r_vidAck;
   assign vidData    = r_vidData;
   assign cpuAck     = r_cpuAck;
   assign cpuData    = r_cpuData;
   assign ramWe      = w_ramWe;
   assign ramAddr    = w_ramAddr;
   assign ramDataOut = cpuDataIn;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;

   localparam int Bits = 16;

   logic            clk;
   logic            reset;
   logic            vidReq;
   logic [Bits-1:0] vidAddr;
   logic            vidAck;
   logic [7:0]      vidData;
   logic            cpuReq;
   logic            cpuWe;
   logic [Bits-1:0] cpuAddr;
   logic [7:0]      cpuDataIn;
   logic            cpuAck;
   logic [7:0]      cpuData;
   logic            ramWe;
   logic [Bits-1:0] ramAddr;
   logic [7:0]      ramDataOut;
   logic [7:0]      ramDataIn;

   logic [7:0]      mem [0:65535];

   int n_checks = 0;
   int n_errors = 0;

   ram_arbiter #(.Bits(Bits)) dut (
      .clk        (clk),
      .reset      (reset),
      .vidReq     (vidReq),
      .vidAddr    (vidAddr),
      .vidAck     (vidAck),
      .vidData    (vidData),
      .cpuReq     (cpuReq),
      .cpuWe      (cpuWe),
      .cpuAddr    (cpuAddr),
      .cpuDataIn  (cpuDataIn),
      .cpuAck     (cpuAck),
      .cpuData    (cpuData),
      .ramWe      (ramWe),
      .ramAddr    (ramAddr),
      .ramDataOut (ramDataOut),
      .ramDataIn  (ramDataIn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, write on rising edge
   assign ramDataIn = mem[ramAddr];
   always @(posedge clk) begin
      if (ramWe) mem[ramAddr] <= ramDataOut;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_vid_ack;
      int n_cpu_ack;
      int b2b;
      int prev_g;
      int g;
      logic [31:0] exp_addr;

      reset     = 1'b0;
      vidReq    = 1'b0;
      vidAddr   = '0;
      cpuReq    = 1'b0;
      cpuWe     = 1'b0;
      cpuAddr   = '0;
      cpuDataIn = 8'h00;
      mem[16'h2000] = 8'h08;
      mem[16'h0100] = 8'h00;
      mem[16'h0200] = 8'h33;
      mem[16'h0300] = 8'h11;

      // Reset state, before any clock edge
      #2;
      chk("rst_vidAck",  32'(vidAck),  32'h0);
      chk("rst_cpuAck",  32'(cpuAck),  32'h0);
      chk("rst_vidData", 32'(vidData), 32'h00);
      chk("rst_cpuData", 32'(cpuData), 32'h00);
      chk("rst_ramWe",   32'(ramWe),   32'h0);
      chk("rst_ramAddr", 32'(ramAddr), 32'h0);

      // Release reset together with a video request: first edge grants VID
      @(negedge clk);
      reset   = 1'b1;
      vidReq  = 1'b1;
      vidAddr = 16'h2000;
      step();
      chk("vid_c1_addr", 32'(ramAddr), 32'h2000);
      chk("vid_c1_we",   32'(ramWe),   32'h0);
      chk("vid_c1_ack",  32'(vidAck),  32'h0);
      step();
      chk("vid_c2_ack",  32'(vidAck),  32'h1);
      chk("vid_c2_data", 32'(vidData), 32'h08);
      chk("vid_c2_addr", 32'(ramAddr), 32'h0);
      vidReq = 1'b0;
      step();
      chk("vid_c3_ack",  32'(vidAck),  32'h0);
      chk("vid_c3_data", 32'(vidData), 32'h08);

      // CPU write 0x5A to 0x0100
      cpuReq    = 1'b1;
      cpuWe     = 1'b1;
      cpuAddr   = 16'h0100;
      cpuDataIn = 8'h5A;
      step();
      chk("wr_c1_we",   32'(ramWe),      32'h1);
      chk("wr_c1_addr", 32'(ramAddr),    32'h0100);
      chk("wr_c1_dout", 32'(ramDataOut), 32'h5A);
      chk("wr_c1_ack",  32'(cpuAck),     32'h0);
      step();
      chk("wr_c2_ack",  32'(cpuAck),       32'h1);
      chk("wr_c2_we",   32'(ramWe),        32'h0);
      chk("wr_c2_data", 32'(cpuData),      32'h00);
      chk("wr_mem",     32'(mem[16'h0100]), 32'h5A);
      cpuReq = 1'b0;
      cpuWe  = 1'b0;
      step();
      chk("wr_c3_ack",  32'(cpuAck), 32'h0);

      // CPU read back from 0x0100
      cpuReq = 1'b1;
      step();
      chk("rd_c1_addr", 32'(ramAddr), 32'h0100);
      chk("rd_c1_we",   32'(ramWe),   32'h0);
      step();
      chk("rd_c2_ack",  32'(cpuAck),  32'h1);
      chk("rd_c2_data", 32'(cpuData), 32'h5A);
      cpuReq = 1'b0;
      step();

      // Simultaneous requests: video first, CPU next cycle
      vidReq  = 1'b1;
      vidAddr = 16'h2000;
      cpuReq  = 1'b1;
      cpuWe   = 1'b0;
      cpuAddr = 16'h0100;
      step();
      chk("both_c1_addr", 32'(ramAddr), 32'h2000);
      step();
      chk("both_c2_addr",   32'(ramAddr), 32'h0100);
      chk("both_c2_vidAck", 32'(vidAck),  32'h1);
      chk("both_c2_cpuAck", 32'(cpuAck),  32'h0);
      vidReq = 1'b0;
      step();
      chk("both_c3_cpuAck", 32'(cpuAck),  32'h1);
      chk("both_c3_vidAck", 32'(vidAck),  32'h0);
      chk("both_c3_data",   32'(cpuData), 32'h5A);
      cpuReq = 1'b0;
      step();

      // Both held high for 30 cycles: VID, CPU, IDLE repeating
      n_vid_ack = 0;
      n_cpu_ack = 0;
      b2b       = 0;
      prev_g    = 0;
      vidReq    = 1'b1;
      cpuReq    = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         exp_addr = (i % 3 == 0) ? 32'h2000 : (i % 3 == 1) ? 32'h0100 : 32'h0;
         chk($sformatf("rr_addr_%0d", i + 1), 32'(ramAddr), exp_addr);
         g = (ramAddr == 16'h2000) ? 1 : (ramAddr == 16'h0100) ? 2 : 0;
         if (g != 0 && g == prev_g) b2b++;
         prev_g = g;
         if (vidAck) n_vid_ack++;
         if (cpuAck) n_cpu_ack++;
      end
      chk("rr_vid_acks", 32'(n_vid_ack), 32'd10);
      chk("rr_cpu_acks", 32'(n_cpu_ack), 32'd10);
      chk("rr_b2b",      32'(b2b),       32'd0);
      vidReq = 1'b0;
      cpuReq = 1'b0;
      step();
      step();

      // CPU write pulse lost to a video grant is cancelled
      vidReq    = 1'b1;
      cpuReq    = 1'b1;
      cpuWe     = 1'b1;
      cpuAddr   = 16'h0200;
      cpuDataIn = 8'hFF;
      step();
      cpuReq = 1'b0;
      chk("cancel_c1_addr", 32'(ramAddr), 32'h2000);
      chk("cancel_c1_we",   32'(ramWe),   32'h0);
      step();
      chk("cancel_c2_vidAck", 32'(vidAck), 32'h1);
      chk("cancel_c2_cpuAck", 32'(cpuAck), 32'h0);
      chk("cancel_c2_we",     32'(ramWe),  32'h0);
      vidReq = 1'b0;
      step();
      chk("cancel_c3_cpuAck", 32'(cpuAck),        32'h0);
      chk("cancel_mem",       32'(mem[16'h0200]), 32'h33);
      cpuWe = 1'b0;
      step();

      // Reset pulse in the middle of a CPU write cycle
      cpuReq    = 1'b1;
      cpuWe     = 1'b1;
      cpuAddr   = 16'h0300;
      cpuDataIn = 8'hC3;
      step();
      chk("abort_c1_we",   32'(ramWe),   32'h1);
      chk("abort_c1_addr", 32'(ramAddr), 32'h0300);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_we",      32'(ramWe),   32'h0);
      chk("abort_addr",    32'(ramAddr), 32'h0);
      chk("abort_vidData", 32'(vidData), 32'h00);
      chk("abort_cpuData", 32'(cpuData), 32'h5A & 32'h0);
      cpuReq = 1'b0;
      cpuWe  = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      vidReq  = 1'b1;
      vidAddr = 16'h2000;
      step();
      chk("abort_r1_cpuAck", 32'(cpuAck),  32'h0);
      chk("abort_r1_addr",   32'(ramAddr), 32'h2000);
      step();
      chk("abort_r2_cpuAck", 32'(cpuAck),        32'h0);
      chk("abort_r2_vidAck", 32'(vidAck),        32'h1);
      chk("abort_r2_vdata",  32'(vidData),       32'h08);
      chk("abort_mem",       32'(mem[16'h0300]), 32'h11);
      vidReq = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
